// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial negator: FSM state encoding and counter sizing.
package serial_pkg;

   typedef logic [0:0] state_t;

   localparam state_t IDLE   = 1'b0;
   localparam state_t ACTIVE = 1'b1;

   function automatic int cnt_w(input int word_w);
      return (word_w <= 2) ? 1 : $clog2(word_w);
   endfunction

endpackage

// File: rtl/serial_negate_lane.sv
// One lane of the serial negator: neg/invert flags and the LSB-first two's-complement bit rule.
// With SERIAL_NEG_OVF_EN defined, also flags a set bit while still un-inverted (most-negative input at the MSB).
module serial_negate_lane (
   input  logic clk,
   input  logic reset_n,
   input  logic proc,
   input  logic start,
   input  logic in_bit,
   input  logic neg_en,
   output logic out_bit,
   output logic ovf
);

   logic neg_q, neg_d;
   logic inv_q, inv_d;
   logic neg, inv;

   always_comb begin
      // A word start overrides the held flags for this very bit.
      neg     = start ? neg_en : neg_q;
      inv     = start ? 1'b0   : inv_q;
      out_bit = in_bit ^ (neg & inv);
      neg_d   = neg_q;
      inv_d   = inv_q;
      if (proc) begin
         neg_d = neg;
         inv_d = neg & (inv | in_bit);
      end
`ifdef SERIAL_NEG_OVF_EN
      ovf = proc & neg & ~inv & in_bit;
`else
      ovf = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         neg_q <= 1'b0;
         inv_q <= 1'b0;
      end else begin
         neg_q <= neg_d;
         inv_q <= inv_d;
      end
   end

endmodule

// File: rtl/serial_negator_mc.sv
// Multi-channel word-framed bit-serial negator: framing FSM, bit counter and registered outputs.
// Overflow detection is built only when SERIAL_NEG_OVF_EN is defined.
module serial_negator_mc #(
   parameter int WORD_W   = 8,
   parameter int CHANNELS = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                in_valid,
   input  logic                in_sof,
   input  logic [CHANNELS-1:0] in_bits,
   input  logic [CHANNELS-1:0] neg_en,
   output logic                out_valid,
   output logic                out_sof,
   output logic                out_eof,
   output logic [CHANNELS-1:0] out_bits,
   output logic                frame_err,
   output logic [CHANNELS-1:0] ovf
);

   import serial_pkg::*;

   localparam int               CNT_W   = cnt_w(WORD_W);
   localparam logic [CNT_W-1:0] MSB_IDX = CNT_W'(WORD_W - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  idx;
   logic              start, proc, ferr, is_msb;
   logic [CHANNELS-1:0] lane_out, lane_ovf;

   logic                out_valid_q, out_valid_d;
   logic                out_sof_q, out_sof_d;
   logic                out_eof_q, out_eof_d;
   logic [CHANNELS-1:0] out_bits_q, out_bits_d;
   logic                frame_err_q, frame_err_d;
   logic [CHANNELS-1:0] ovf_q, ovf_d;

   genvar g;
   generate
      for (g = 0; g < CHANNELS; g++) begin : g_lane
         serial_negate_lane u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .proc    (proc),
            .start   (start),
            .in_bit  (in_bits[g]),
            .neg_en  (neg_en[g]),
            .out_bit (lane_out[g]),
            .ovf     (lane_ovf[g])
         );
      end
   endgenerate

   always_comb begin
      // Any in_sof restarts a word; seen while ACTIVE it means the previous word was cut short.
      start  = in_valid & in_sof;
      proc   = in_valid & (in_sof | (state_q == ACTIVE));
      ferr   = start & (state_q == ACTIVE);
      idx    = start ? '0 : cnt_q;
      is_msb = proc & (idx == MSB_IDX);

      state_d = state_q;
      cnt_d   = cnt_q;
      if (proc) begin
         if (is_msb) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            state_d = ACTIVE;
            cnt_d   = idx + 1'b1;
         end
      end

      out_valid_d = proc;
      out_sof_d   = proc ? start    : out_sof_q;
      out_eof_d   = proc ? is_msb   : out_eof_q;
      out_bits_d  = proc ? lane_out : out_bits_q;
      frame_err_d = ferr;
      ovf_d       = lane_ovf & {CHANNELS{is_msb}};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
         out_bits_q  <= '0;
         frame_err_q <= 1'b0;
         ovf_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_sof_q   <= out_sof_d;
         out_eof_q   <= out_eof_d;
         out_bits_q  <= out_bits_d;
         frame_err_q <= frame_err_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sof   = out_sof_q;
   assign out_eof   = out_eof_q;
   assign out_bits  = out_bits_q;
   assign frame_err = frame_err_q;
   assign ovf       = ovf_q;

endmodule
